multi_port_fifo: RTL and testbench

MULTI_PORT_FIFO -- requirements
Module: multi_port_fifo

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_lane_compact.sv | 33 +++
 rtl/multi_port_fifo.sv | 115 +++++++++++
 tb/tb_multi_port_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-lane FIFO: pointer/count widths and lane popcount.
package fifo_pkg;

  localparam int unsigned MaxLanes = 4;

  // Pointers carry one extra wrap bit above the slot index.
  function automatic int unsigned ptr_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [2:0] lane_popcount(logic [MaxLanes-1:0] mask);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MaxLanes; i++) begin
      n = n + {2'b00, mask[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_lane_compact.sv
// Maps an enqueue valid mask to per-lane slot offsets so valid lanes pack densely from tail.
module fifo_lane_compact
  import fifo_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned OFF_W = 3
) (
  input  logic [LANES-1:0]            valid,
  output logic [LANES-1:0][OFF_W-1:0] offset,
  output logic [OFF_W-1:0]            total
);

  logic [OFF_W-1:0]    acc;
  logic [MaxLanes-1:0] mask4;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < LANES; i++) begin
      offset[i] = acc;
      if (valid[i]) begin
        acc = acc + OFF_W'(1);
      end
    end
  end

  always_comb begin
    mask4               = '0;
    mask4[LANES-1:0]    = valid;
    total               = OFF_W'(lane_popcount(mask4));
  end

endmodule

// File: rtl/multi_port_fifo.sv
// Multi-lane FIFO: all-or-nothing wide enqueue, in-order multi-lane dequeue, wrap-bit pointers.
module multi_port_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ENQ_PORTS  = 2,
  parameter int unsigned DEQ_PORTS  = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [ENQ_PORTS-1:0]                 enq_valid,
  input  logic [ENQ_PORTS-1:0][DATA_WIDTH-1:0] enq_data,
  output logic                                 enq_ready,
  output logic [DEQ_PORTS-1:0]                 deq_valid,
  output logic [DEQ_PORTS-1:0][DATA_WIDTH-1:0] deq_data,
  input  logic [DEQ_PORTS-1:0]                 deq_pop,
  output logic [$clog2(DEPTH):0]               count,
  output logic                                 full,
  output logic                                 empty
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam int unsigned IdxW = PtrW - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW-1:0] free, n_enq, n_deq;
  logic [ENQ_PORTS-1:0][PtrW-1:0] enq_off;
  logic [ENQ_PORTS-1:0][IdxW-1:0] wr_idx;
  logic [PtrW-1:0] wr_slot, rd_slot;
  logic            wr_en, run;

  fifo_lane_compact #(
    .LANES (ENQ_PORTS),
    .OFF_W (PtrW)
  ) u_compact (
    .valid  (enq_valid),
    .offset (enq_off),
    .total  (n_enq)
  );

  always_comb begin
    count     = CntW'(tail_q - head_q);
    free      = PtrW'(DEPTH) - count;
    full      = (count == CntW'(DEPTH));
    empty     = (count == '0);
    enq_ready = (free >= n_enq);
    // Reset and flush both suppress the write even though enq_ready stays live.
    wr_en     = enq_ready && !flush && !reset;
  end

  always_comb begin
    wr_slot = '0;
    wr_idx  = '0;
    for (int i = 0; i < ENQ_PORTS; i++) begin
      wr_slot   = tail_q + enq_off[i];
      wr_idx[i] = wr_slot[IdxW-1:0];
    end
  end

  always_comb begin
    rd_slot   = '0;
    deq_valid = '0;
    deq_data  = '0;
    n_deq     = '0;
    run       = 1'b1;
    for (int i = 0; i < DEQ_PORTS; i++) begin
      rd_slot      = head_q + PtrW'(i);
      deq_valid[i] = (PtrW'(i) < count);
      if (deq_valid[i]) begin
        deq_data[i] = mem[rd_slot[IdxW-1:0]];
      end
      // Only an unbroken run of pops from lane 0 counts.
      if (run && deq_pop[i] && deq_valid[i]) begin
        n_deq = n_deq + PtrW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  always_comb begin
    head_d = head_q + n_deq;
    tail_d = enq_ready ? tail_q + n_enq : tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < ENQ_PORTS; i++) begin
        if (enq_valid[i]) begin
          mem[wr_idx[i]] <= enq_data[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_port_fifo.sv
// Directed bench for multi_port_fifo with a queue-based reference model checked every cycle.
module tb_multi_port_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int EP    = 2;
  localparam int DP    = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush;
  logic [EP-1:0]        enq_valid;
  logic [EP-1:0][DW-1:0] enq_data;
  logic                 enq_ready;
  logic [DP-1:0]        deq_valid;
  logic [DP-1:0][DW-1:0] deq_data;
  logic [DP-1:0]        deq_pop;
  logic [3:0]           count;
  logic                 full;
  logic                 empty;

  multi_port_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ENQ_PORTS  (EP),
    .DEQ_PORTS  (DP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .deq_pop   (deq_pop),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  bit          chk_en   = 1'b0;
  logic        rdy;
  logic [31:0] model_q[$];
  int          nenq, ndeq, sz;
  bit          mready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated with the same inputs the DUT sees at each edge.
  initial forever begin
    @(posedge clk);
    if (reset || flush) begin
      model_q.delete();
    end else begin
      nenq   = $countones(enq_valid);
      mready = (DEPTH - model_q.size()) >= nenq;
      ndeq   = 0;
      for (int i = 0; i < DP; i++) begin
        if (deq_pop[i] && (i < model_q.size()) && (ndeq == i)) ndeq++;
      end
      repeat (ndeq) void'(model_q.pop_front());
      if (mready) begin
        for (int i = 0; i < EP; i++) begin
          if (enq_valid[i]) model_q.push_back(enq_data[i]);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      sz = model_q.size();
      check("m_count", 32'(count), 32'(sz));
      check("m_full", 32'(full), 32'(sz == DEPTH));
      check("m_empty", 32'(empty), 32'(sz == 0));
      check("m_enq_ready", 32'(enq_ready), 32'((DEPTH - sz) >= $countones(enq_valid)));
      for (int i = 0; i < DP; i++) begin
        check("m_deq_valid", 32'(deq_valid[i]), 32'(i < sz));
        check("m_deq_data", deq_data[i], (i < sz) ? model_q[i] : 32'h0);
      end
    end
  end

  task automatic cyc(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] pop, input logic fl);
    enq_valid   = ev;
    enq_data[0] = d0;
    enq_data[1] = d1;
    deq_pop     = pop;
    flush       = fl;
    #1;
    rdy = enq_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    enq_valid = '0;
    enq_data  = '0;
    deq_pop   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_deq_data", deq_data[0], 32'h0);
    check("rst_enq_ready", 32'(enq_ready), 32'd1);

    // Fill with four 2-wide pairs.
    for (int k = 0; k < 4; k++) begin
      cyc(2'b11, 32'hA000_0000 + 32'(2 * k), 32'hA000_0001 + 32'(2 * k), 2'b00, 1'b0);
      check("fill_ready", 32'(rdy), 32'd1);
      check("fill_count", 32'(count), 32'(2 * (k + 1)));
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_head0", deq_data[0], 32'hA000_0000);
    check("fill_head1", deq_data[1], 32'hA000_0001);

    // Full: no credit from same-cycle pops.
    cyc(2'b01, 32'hDEAD_0001, 32'h0, 2'b11, 1'b0);
    check("full_pop_ready", 32'(rdy), 32'd0);
    check("full_pop_count", 32'(count), 32'd6);
    check("full_pop_head", deq_data[0], 32'hA000_0002);

    // Count 7: 2-wide rejected, single lane 1 accepted into slot tail.
    cyc(2'b01, 32'h1111_0007, 32'h0, 2'b00, 1'b0);
    check("c7_count", 32'(count), 32'd7);
    cyc(2'b11, 32'h0000_BAD0, 32'h0000_BAD1, 2'b00, 1'b0);
    check("c7_reject_ready", 32'(rdy), 32'd0);
    check("c7_reject_count", 32'(count), 32'd7);
    cyc(2'b10, 32'h0, 32'hC0C0_C0C0, 2'b00, 1'b0);
    check("c7_lane1_ready", 32'(rdy), 32'd1);
    check("c7_lane1_count", 32'(count), 32'd8);
    repeat (3) cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    check("drain_count", 32'(count), 32'd2);
    check("drain_tail0", deq_data[0], 32'h1111_0007);
    check("drain_tail1", deq_data[1], 32'hC0C0_C0C0);
    cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    check("drain_empty", 32'(empty), 32'd1);

    // Pop truncation to valid lanes, and pops above a zero ignored.
    cyc(2'b01, 32'hD000_0000, 32'h0, 2'b00, 1'b0);
    check("one_count", 32'(count), 32'd1);
    cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    check("one_pop_count", 32'(count), 32'd0);
    check("one_pop_empty", 32'(empty), 32'd1);
    cyc(2'b11, 32'hE000_0000, 32'hF000_0000, 2'b00, 1'b0);
    cyc(2'b01, 32'h6000_0000, 32'h0, 2'b00, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 2'b10, 1'b0);
    check("gap_pop_count", 32'(count), 32'd3);
    check("gap_pop_head", deq_data[0], 32'hE000_0000);

    // Sustained 2-in/1-out traffic across the pointer wrap.
    for (int k = 0; k < 20; k++) begin
      cyc(2'b11, 32'h3500_0000 + 32'(2 * k), 32'h3500_0001 + 32'(2 * k), 2'b01, 1'b0);
    end
    check("wrap_count", 32'(count), 32'd7);

    // Flush wins over a same-cycle enqueue.
    cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    check("pre_flush_count", 32'(count), 32'd5);
    cyc(2'b11, 32'h0000_00F1, 32'h0000_00F2, 2'b00, 1'b1);
    check("flush_ready", 32'(rdy), 32'd1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);

    // Reset in the middle of a burst.
    repeat (3) cyc(2'b11, 32'h7700_0000, 32'h7700_0001, 2'b00, 1'b0);
    check("burst_count", 32'(count), 32'd6);
    reset = 1'b1;
    cyc(2'b11, 32'h7700_0002, 32'h7700_0003, 2'b11, 1'b0);
    reset = 1'b0;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    cyc(2'b11, 32'h600D_0000, 32'h600D_0001, 2'b00, 1'b0);
    check("post_rst_count", 32'(count), 32'd2);
    check("post_rst_head0", deq_data[0], 32'h600D_0000);
    check("post_rst_head1", deq_data[1], 32'h600D_0001);

    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
